// File: rtl/rpd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rpd_pkg
//  Purpose  : Shared types and default widths for the record sequencer path.
//  Revision : 1.0  initial release
// ============================================================================
package rpd_pkg;

    // Default widths for the record length counter and the record index.
    localparam int unsigned c_CTR_WIDTH = 24;
    localparam int unsigned c_ID_WIDTH  = 8;

    // Sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        REC_IDLE = 2'd0,
        REC_ARM  = 2'd1,
        REC_RUN  = 2'd2,
        REC_DONE = 2'd3
    } rec_state_t;

endpackage
`default_nettype wire

// File: rtl/rec_len_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : rec_len_ctr
//  Purpose  : Loadable down-counter of samples remaining in a record, with a
//             flag that marks the final sample. Saturates at zero.
//  Revision : 1.0  initial release
// ============================================================================
module rec_len_ctr
    import rpd_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = c_CTR_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_ce,
    input  logic                 i_load,
    input  logic [CTR_WIDTH-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_last
);

    localparam logic [CTR_WIDTH-1:0] c_ONE = CTR_WIDTH'(1);

    logic [CTR_WIDTH-1:0] r_count;

    // Load takes priority over decrement; the count never wraps below zero.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_count <= '0;
        end else if (i_ce) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_dec && (r_count != '0)) begin
                r_count <= r_count - c_ONE;
            end
        end
    end

    assign o_last = (r_count == c_ONE);

endmodule
`default_nettype wire

// File: rtl/record_seq.sv
`default_nettype none
// ============================================================================
//  Module   : record_seq
//  Purpose  : Record sequencer. Arms a record, clears the downstream sample
//             counter, gates exactly N ADC sample strobes through, then
//             reports completion. Supports continuous records and abort.
//  Revision : 1.0  initial release
// ============================================================================
module record_seq
    import rpd_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = c_CTR_WIDTH,
    parameter int unsigned ID_WIDTH  = c_ID_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_ce,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_cont,
    input  logic [CTR_WIDTH-1:0] i_cfg_len,
    input  logic                 i_sample_stb,
    output logic                 o_new_record,
    output logic                 o_signal_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_aborted,
    output logic [ID_WIDTH-1:0]  o_rec_id,
    output logic [1:0]           o_state
);

    localparam logic [ID_WIDTH-1:0] c_ID_ONE = ID_WIDTH'(1);

    rec_state_t           r_state;
    rec_state_t           w_state_nxt;
    logic [CTR_WIDTH-1:0] r_len;
    logic [ID_WIDTH-1:0]  r_rec_id;
    logic                 r_aborted;

    logic                 w_load;
    logic [CTR_WIDTH-1:0] w_load_val;
    logic                 w_abort_take;
    logic                 w_sample_pass;
    logic                 w_last;

    // Remaining-sample counter; reloaded on start and on continuous restart.
    rec_len_ctr #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_len_ctr (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_ce       (i_ce),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_sample_pass),
        .o_last     (w_last)
    );

    // Next-state decode; abort beats the final sample in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_load_val    = r_len;
        w_abort_take  = 1'b0;
        w_sample_pass = 1'b0;
        case (r_state)
            REC_IDLE: begin
                if (i_start && (i_cfg_len != '0)) begin
                    w_state_nxt = REC_ARM;
                    w_load      = 1'b1;
                    w_load_val  = i_cfg_len;
                end
            end
            REC_ARM: begin
                if (i_abort) begin
                    w_state_nxt  = REC_IDLE;
                    w_abort_take = 1'b1;
                end else begin
                    w_state_nxt = REC_RUN;
                end
            end
            REC_RUN: begin
                if (i_abort) begin
                    w_state_nxt  = REC_IDLE;
                    w_abort_take = 1'b1;
                end else if (i_sample_stb) begin
                    w_sample_pass = 1'b1;
                    if (w_last) begin
                        w_state_nxt = REC_DONE;
                    end
                end
            end
            REC_DONE: begin
                // Continuous mode reuses the latched length, not i_cfg_len.
                if (i_cont) begin
                    w_state_nxt = REC_ARM;
                    w_load      = 1'b1;
                    w_load_val  = r_len;
                end else begin
                    w_state_nxt = REC_IDLE;
                end
            end
            default: begin
                w_state_nxt = REC_IDLE;
            end
        endcase
    end

    // State register, advanced only on enabled cycles.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= REC_IDLE;
        end else if (i_ce) begin
            r_state <= w_state_nxt;
        end
    end

    // Latched record length, captured whenever the counter is loaded.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_len <= '0;
        end else if (i_ce && w_load) begin
            r_len <= w_load_val;
        end
    end

    // Completed-record index, bumped once per DONE cycle and free to wrap.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_rec_id <= '0;
        end else if (i_ce && (r_state == REC_DONE)) begin
            r_rec_id <= r_rec_id + c_ID_ONE;
        end
    end

    // Abort flag, held across disabled cycles until the next enabled one.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_aborted <= 1'b0;
        end else if (i_ce) begin
            r_aborted <= w_abort_take;
        end
    end

    // Pulses are qualified by i_ce so each appears on exactly one enabled cycle.
    assign o_new_record   = (r_state == REC_ARM) & i_ce;
    assign o_done         = (r_state == REC_DONE) & i_ce;
    assign o_aborted      = r_aborted & i_ce;
    assign o_signal_valid = w_sample_pass & i_ce;
    assign o_busy         = (r_state == REC_ARM) | (r_state == REC_RUN);
    assign o_rec_id       = r_rec_id;
    assign o_state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_record_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_record_seq
//  Purpose  : Self-checking bench for record_seq against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_record_seq;

    localparam int unsigned c_CW = 24;
    localparam int unsigned c_IW = 8;

    logic            clk;
    logic            i_nrst;
    logic            i_ce;
    logic            i_start;
    logic            i_abort;
    logic            i_cont;
    logic [c_CW-1:0] i_cfg_len;
    logic            i_sample_stb;
    logic            o_new_record;
    logic            o_signal_valid;
    logic            o_busy;
    logic            o_done;
    logic            o_aborted;
    logic [c_IW-1:0] o_rec_id;
    logic [1:0]      o_state;

    int n_vec;
    int n_err;

    // Behavioural model: which phase of a record we are in, plus counts.
    bit m_arming;
    bit m_recording;
    bit m_finishing;
    bit m_abort_note;
    int m_left;
    int m_len;
    int m_id;

    record_seq #(
        .CTR_WIDTH (c_CW),
        .ID_WIDTH  (c_IW)
    ) dut (
        .i_clk          (clk),
        .i_nrst         (i_nrst),
        .i_ce           (i_ce),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_cont         (i_cont),
        .i_cfg_len      (i_cfg_len),
        .i_sample_stb   (i_sample_stb),
        .o_new_record   (o_new_record),
        .o_signal_valid (o_signal_valid),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_aborted      (o_aborted),
        .o_rec_id       (o_rec_id),
        .o_state        (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_arming     = 1'b0;
        m_recording  = 1'b0;
        m_finishing  = 1'b0;
        m_abort_note = 1'b0;
        m_left       = 0;
        m_len        = 0;
        m_id         = 0;
    endtask

    // Compare every output against what the model predicts for this cycle.
    task automatic check_outputs();
        int exp_state;
        exp_state = m_arming ? 1 : m_recording ? 2 : m_finishing ? 3 : 0;
        chk_eq("new_record", 32'(o_new_record), 32'(m_arming & i_ce));
        chk_eq("signal_valid", 32'(o_signal_valid),
               32'(m_recording & i_sample_stb & i_ce & ~i_abort));
        chk_eq("busy", 32'(o_busy), 32'(m_arming | m_recording));
        chk_eq("done", 32'(o_done), 32'(m_finishing & i_ce));
        chk_eq("aborted", 32'(o_aborted), 32'(m_abort_note & i_ce));
        chk_eq("rec_id", 32'(o_rec_id), 32'(m_id));
        chk_eq("state", 32'(o_state), 32'(exp_state));
    endtask

    // Advance the model over one clock edge using the applied inputs.
    task automatic model_update();
        if (!i_ce) return;
        m_abort_note = (m_arming | m_recording) & i_abort;
        if (m_arming) begin
            m_arming = 1'b0;
            if (!i_abort) m_recording = 1'b1;
        end else if (m_recording) begin
            if (i_abort) begin
                m_recording = 1'b0;
            end else if (i_sample_stb) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_recording = 1'b0;
                    m_finishing = 1'b1;
                end
            end
        end else if (m_finishing) begin
            m_finishing = 1'b0;
            m_id = (m_id + 1) % (1 << c_IW);
            if (i_cont) begin
                m_arming = 1'b1;
                m_left   = m_len;
            end
        end else begin
            if (i_start && (i_cfg_len != '0)) begin
                m_len    = int'(i_cfg_len);
                m_left   = m_len;
                m_arming = 1'b1;
            end
        end
    endtask

    // One cycle: drive on the falling edge, check shortly after, then model.
    task automatic step(input bit s, input bit a, input bit c, input int len,
                        input bit stb, input bit ce);
        @(negedge clk);
        i_start      = s;
        i_abort      = a;
        i_cont       = c;
        i_cfg_len    = c_CW'(len);
        i_sample_stb = stb;
        i_ce         = ce;
        #1;
        check_outputs();
        model_update();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        @(negedge clk);
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_cont       = 1'b0;
        i_cfg_len    = '0;
        i_sample_stb = 1'b0;
        i_ce         = 1'b1;
        #1;
        i_nrst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        #2;
        i_nrst = 1'b1;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        i_nrst       = 1'b1;
        i_ce         = 1'b1;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_cont       = 1'b0;
        i_cfg_len    = '0;
        i_sample_stb = 1'b0;
        model_reset();
        async_reset();

        // Basic record of 4 with a strobe every cycle; start while busy ignored.
        step(1, 0, 0, 4, 0, 1);
        for (int i = 0; i < 7; i++) step(i == 2, 0, 0, 9, 1, 1);
        chk_eq("rec_id_after_1", 32'(o_rec_id), 32'd1);

        // Length 3, sparse strobes with clock enable toggling.
        step(1, 0, 0, 3, 0, 1);
        for (int i = 0; i < 24; i++) step(0, 0, 0, 3, (i % 3) == 0, (i % 2) == 0);

        // Length 5, abort after two samples.
        step(1, 0, 0, 5, 0, 1);
        for (int i = 0; i < 8; i++) step(0, i == 3, 0, 5, 1, 1);

        // Abort coincident with the final of three samples.
        step(1, 0, 0, 3, 0, 1);
        for (int i = 0; i < 6; i++) step(0, i == 3, 0, 3, 1, 1);

        // Abort while arming, and aborts in idle/done ignored.
        step(1, 0, 0, 2, 0, 1);
        step(0, 1, 0, 2, 1, 1);
        step(0, 1, 0, 2, 1, 1);
        step(0, 0, 0, 2, 0, 1);

        // Continuous records of 2; cfg_len changes mid-run are not picked up.
        step(1, 0, 1, 2, 0, 1);
        for (int i = 0; i < 16; i++) step(0, i == 10, 1, (i > 3) ? 7 : 2, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 2, 1, 1);

        // Zero length start ignored, then reset in the middle of a record.
        step(1, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 6, 0, 1);
        step(0, 0, 0, 6, 1, 1);
        step(0, 0, 0, 6, 1, 1);
        async_reset();
        step(0, 0, 0, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 6)),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 4) != 0);
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
